// File: rtl/sgd_pkg.sv
// Shared definitions for the SGD training engine: state encoding, default
// word geometry and signed saturation limits.
package sgd_pkg;
    localparam int DEF_W_LEN    = 16;
    localparam int DEF_FRAC     = 8;
    localparam int DEF_MAX_FEAT = 15;

    typedef enum logic [2:0] {
        IDLE, LOAD_W, FETCH, PREDICT, ERR, UPDATE, DONE
    } state_t;

    // Largest and smallest values representable in a signed word of width w.
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction
endpackage

// File: rtl/fxp_mac.sv
// One signed fixed-point multiply: full-width product rescaled by FRAC bits.
module fxp_mac
    import sgd_pkg::*;
#(
    parameter int W_LEN = DEF_W_LEN,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic signed [W_LEN-1:0]   a,
    input  logic signed [W_LEN-1:0]   b,
    output logic signed [2*W_LEN-1:0] p
);
    logic signed [2*W_LEN-1:0] prod;

    assign prod = (2*W_LEN)'(a) * (2*W_LEN)'(b);
    assign p    = prod >>> FRAC;
endmodule

// File: rtl/sgd_engine.sv
// Linear-regression SGD trainer: streams points from a read port, predicts,
// computes a saturated error and updates the weight vector once per point.
module sgd_engine
    import sgd_pkg::*;
#(
    parameter int W_LEN    = DEF_W_LEN,
    parameter int FRAC     = DEF_FRAC,
    parameter int MAX_FEAT = DEF_MAX_FEAT,
    parameter int ADDR_W   = 12,
    localparam int DW      = (MAX_FEAT + 1) * W_LEN
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [3:0]        feat,
    input  logic [ADDR_W-1:0] data_points,
    input  logic [7:0]        epoch,
    input  logic [3:0]        learn_rate,
    input  logic              init_w,
    output logic [ADDR_W-1:0] addr,
    output logic              rd_en,
    input  logic [DW-1:0]     rd_data,
    input  logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic [7:0]        epoch_cnt,
    input  logic [3:0]        w_sel,
    output logic [W_LEN-1:0]  w_out,
    output state_t            state_dbg
);
    localparam int     ACC_W = W_LEN + 8;
    localparam int     SUM_W = 2 * W_LEN + 1;
    localparam longint W_MAX = sat_max(W_LEN);
    localparam longint W_MIN = sat_min(W_LEN);

    state_t                    state, state_nx;
    logic [3:0]                feat_q, lr_q;
    logic [ADDR_W-1:0]         dp_q;
    logic [7:0]                epoch_q;
    logic                      init_q;
    logic signed [W_LEN-1:0]   w_q   [0:MAX_FEAT];
    logic signed [W_LEN-1:0]   w_upd [0:MAX_FEAT];
    logic signed [W_LEN-1:0]   x_q   [1:MAX_FEAT];
    logic signed [W_LEN-1:0]   mac_a [1:MAX_FEAT];
    logic signed [2*W_LEN-1:0] prod  [1:MAX_FEAT];
    logic signed [W_LEN-1:0]   y_q, err_q, err_d;
    logic signed [ACC_W-1:0]   yhat_q, yhat_d;
    logic                      last_pt, last_epoch;

    function automatic logic signed [W_LEN-1:0] sat(input logic signed [SUM_W-1:0] v);
        if (v > SUM_W'(W_MAX))      return W_LEN'(W_MAX);
        else if (v < SUM_W'(W_MIN)) return W_LEN'(W_MIN);
        else                        return v[W_LEN-1:0];
    endfunction

    // The multipliers see weights while predicting and the error while updating.
    for (genvar j = 1; j <= MAX_FEAT; j++) begin : g_mac
        assign mac_a[j] = (state == UPDATE) ? err_q : w_q[j];
        fxp_mac #(.W_LEN(W_LEN), .FRAC(FRAC)) u_mac (
            .a (mac_a[j]),
            .b (x_q[j]),
            .p (prod[j])
        );
    end

    always_comb begin
        yhat_d = ACC_W'(w_q[0]);
        for (int j = 1; j <= MAX_FEAT; j++)
            if (j <= int'(feat_q)) yhat_d = yhat_d + $signed(prod[j][ACC_W-1:0]);
        err_d = sat(SUM_W'(y_q) - SUM_W'(yhat_q));
        w_upd[0] = sat(SUM_W'(w_q[0]) + SUM_W'(err_q >>> lr_q));
        for (int j = 1; j <= MAX_FEAT; j++)
            w_upd[j] = (j <= int'(feat_q)) ? sat(SUM_W'(w_q[j]) + SUM_W'(prod[j] >>> lr_q))
                                           : w_q[j];
    end

    assign last_pt    = (addr == dp_q);
    assign last_epoch = ((epoch_cnt + 8'd1) == epoch_q);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = LOAD_W;
            LOAD_W:     if (!init_q || rd_valid)
                            state_nx = (epoch_q == 8'd0 || dp_q == '0) ? DONE : FETCH;
            FETCH:      if (rd_valid) state_nx = PREDICT;
            PREDICT:    state_nx = ERR;
            ERR:        state_nx = UPDATE;
            UPDATE:     state_nx = (last_pt && last_epoch) ? DONE : FETCH;
            default:    state_nx = IDLE;
        endcase
    end

    assign rd_en     = (state == FETCH) || (state == LOAD_W && init_q);
    assign busy      = (state == LOAD_W) || (state == FETCH) || (state == PREDICT) ||
                       (state == ERR) || (state == UPDATE);
    assign done      = (state == DONE);
    assign state_dbg = state;

    always_comb begin
        w_out = '0;
        for (int j = 0; j <= MAX_FEAT; j++)
            if (w_sel == 4'(j)) w_out = w_q[j];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            feat_q    <= '0;
            lr_q      <= '0;
            dp_q      <= '0;
            epoch_q   <= '0;
            init_q    <= 1'b0;
            addr      <= '0;
            epoch_cnt <= '0;
            y_q       <= '0;
            err_q     <= '0;
            yhat_q    <= '0;
            for (int j = 0; j <= MAX_FEAT; j++) w_q[j] <= '0;
            for (int j = 1; j <= MAX_FEAT; j++) x_q[j] <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE, DONE: if (start) begin
                    feat_q    <= feat;
                    lr_q      <= learn_rate;
                    dp_q      <= data_points;
                    epoch_q   <= epoch;
                    init_q    <= init_w;
                    addr      <= '0;
                    epoch_cnt <= '0;
                end
                LOAD_W: begin
                    if (!init_q)
                        for (int j = 0; j <= MAX_FEAT; j++) w_q[j] <= '0;
                    else if (rd_valid)
                        for (int j = 0; j <= MAX_FEAT; j++) w_q[j] <= rd_data[DW-1-j*W_LEN -: W_LEN];
                    if (!init_q || rd_valid) addr <= ADDR_W'(1);
                end
                FETCH: if (rd_valid) begin
                    y_q <= rd_data[DW-1 -: W_LEN];
                    for (int j = 1; j <= MAX_FEAT; j++) x_q[j] <= rd_data[DW-1-j*W_LEN -: W_LEN];
                end
                PREDICT: yhat_q <= yhat_d;
                ERR:     err_q  <= err_d;
                UPDATE: begin
                    for (int j = 0; j <= MAX_FEAT; j++) w_q[j] <= w_upd[j];
                    if (last_pt) begin
                        addr      <= ADDR_W'(1);
                        epoch_cnt <= epoch_cnt + 8'd1;
                    end else begin
                        addr <= addr + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sgd_engine.sv
// Bench for sgd_engine: a table of single-point training vectors with
// hand-computed weights, plus sequences for wait states, epochs and reset.
`timescale 1ns/1ps
module tb_sgd_engine;
    import sgd_pkg::*;

    localparam int W  = 16;
    localparam int MF = 15;
    localparam int AW = 12;
    localparam int DW = (MF + 1) * W;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    feat = '0;
    logic [AW-1:0] data_points = '0;
    logic [7:0]    epoch = '0;
    logic [3:0]    learn_rate = '0;
    logic          init_w = 1'b0;
    logic [AW-1:0] addr;
    logic          rd_en;
    logic [DW-1:0] rd_data = '0;
    logic          rd_valid = 1'b0;
    logic          busy;
    logic          done;
    logic [7:0]    epoch_cnt;
    logic [3:0]    w_sel = '0;
    logic [W-1:0]  w_out;
    state_t        state_dbg;

    sgd_engine dut (
        .CLK(CLK), .RST(RST), .start(start), .feat(feat), .data_points(data_points),
        .epoch(epoch), .learn_rate(learn_rate), .init_w(init_w), .addr(addr),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .done(done), .epoch_cnt(epoch_cnt), .w_sel(w_sel), .w_out(w_out),
        .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    // Memory responder: answers a read after lat idle cycles.
    logic [DW-1:0] mem [0:7];
    int            lat = 0;
    int            wait_cnt = 0;
    bit            hi_seen = 1'b0;

    always @(negedge CLK) begin
        if (rd_valid) begin
            rd_valid = 1'b0;
            wait_cnt = 0;
        end
        if (rd_en) begin
            if (addr != '0) hi_seen = 1'b1;
            if (wait_cnt >= lat) begin
                rd_valid = 1'b1;
                rd_data  = mem[addr[2:0]];
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] put(input logic [DW-1:0] word, input int k, input logic [W-1:0] v);
        logic [DW-1:0] r;
        r = word;
        r[DW-1-k*W -: W] = v;
        return r;
    endfunction

    function automatic logic [DW-1:0] pt(input logic [W-1:0] y, input logic [W-1:0] x1);
        return put(put('0, 0, y), 1, x1);
    endfunction

    task automatic configure(input logic [3:0] f, input logic [AW-1:0] dp, input logic [7:0] ep,
                             input logic [3:0] lr, input logic iw);
        feat = f; data_points = dp; epoch = ep; learn_rate = lr; init_w = iw;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge CLK);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int cyc);
        cyc = 0;
        while (!done && cyc < budget) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        check({name, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic read_w(input int k, output logic [W-1:0] v);
        w_sel = 4'(k);
        #1;
        v = w_out;
    endtask

    typedef struct {
        logic [3:0]       feat;
        logic [3:0]       lr;
        logic             init_w;
        logic [3:0][15:0] wi;
        logic [15:0]      y;
        logic [3:0][15:0] x;
        logic [3:0][15:0] ew;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    task automatic set_vec(input int i, input logic [3:0] f, input logic [3:0] lr, input logic iw,
                           input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                           input logic [15:0] w3, input logic [15:0] y, input logic [15:0] x1,
                           input logic [15:0] x2, input logic [15:0] x3, input logic [15:0] e0,
                           input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
        vecs[i].feat = f; vecs[i].lr = lr; vecs[i].init_w = iw;
        vecs[i].wi[0] = w0; vecs[i].wi[1] = w1; vecs[i].wi[2] = w2; vecs[i].wi[3] = w3;
        vecs[i].y = y;
        vecs[i].x[0] = '0; vecs[i].x[1] = x1; vecs[i].x[2] = x2; vecs[i].x[3] = x3;
        vecs[i].ew[0] = e0; vecs[i].ew[1] = e1; vecs[i].ew[2] = e2; vecs[i].ew[3] = e3;
    endtask

    // One point, one epoch, then the first four weights against the table.
    task automatic run_vec(input int i, input string tag);
        logic [DW-1:0] wd;
        logic [W-1:0]  got;
        int            cyc;
        wd = '0;
        for (int k = 0; k < 4; k++) wd = put(wd, k, vecs[i].wi[k]);
        mem[0] = wd;
        wd = put('0, 0, vecs[i].y);
        for (int k = 1; k < 4; k++) wd = put(wd, k, vecs[i].x[k]);
        mem[1] = wd;
        lat = 0;
        configure(vecs[i].feat, 12'd1, 8'd1, vecs[i].lr, vecs[i].init_w);
        pulse_start();
        wait_done($sformatf("%s%0d", tag, i), 50, cyc);
        check($sformatf("%s%0d_epoch_cnt", tag, i), 32'(epoch_cnt), 32'd1);
        for (int k = 0; k < 4; k++) begin
            read_w(k, got);
            check($sformatf("%s%0d_w%0d", tag, i, k), 32'(got), 32'(vecs[i].ew[k]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]  got;
        logic [DW-1:0] wd;
        int            cyc;

        for (int a = 0; a < 8; a++) mem[a] = '0;

        //             i f     lr    iw    w0       w1       w2       w3       y        x1       x2       x3       e0       e1       e2       e3
        set_vec(0, 4'd1, 4'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0200, 16'h0100, 16'h0000, 16'h0000, 16'h0200, 16'h0200, 16'h0000, 16'h0000);
        set_vec(1, 4'd1, 4'd0, 1'b1, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
        set_vec(2, 4'd2, 4'd1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0300, 16'h0100, 16'h0100, 16'h0080, 16'h0100, 16'h0080, 16'h0080, 16'h0040, 16'h0300);
        set_vec(3, 4'd3, 4'd2, 1'b1, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0200, 16'h0100, 16'hFF00, 16'h0040, 16'hFF80, 16'hFF40, 16'h00C0);
        set_vec(4, 4'd1, 4'd0, 1'b1, 16'h6000, 16'h6000, 16'h0000, 16'h0000, 16'h7FFF, 16'hFF00, 16'h0000, 16'h0000, 16'h7FFF, 16'hE001, 16'h0000, 16'h0000);
        set_vec(5, 4'd0, 4'd0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0300, 16'h0100, 16'h0100, 16'h0000, 16'h0300, 16'h0000, 16'h0000, 16'h0000);
        set_vec(6, 4'd1, 4'd0, 1'b1, 16'h9000, 16'h9000, 16'h0000, 16'h0000, 16'h8000, 16'hFF00, 16'h0000, 16'h0000, 16'h8000, 16'h1000, 16'h0000, 16'h0000);

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_epoch_cnt", 32'(epoch_cnt), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        read_w(0, got);
        check("rst_w0", 32'(got), 32'd0);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < NV; i++) run_vec(i, "vec");

        // epoch=0 with init_w=1: weights come from address 0, no point is fetched
        wd = '0;
        wd = put(wd, 0, 16'h1234);
        wd = put(wd, 5, 16'hFEDC);
        wd = put(wd, 15, 16'h0101);
        mem[0] = wd;
        lat = 2;
        hi_seen = 1'b0;
        configure(4'd3, 12'd3, 8'd0, 4'd0, 1'b1);
        pulse_start();
        wait_done("ep0", 50, cyc);
        check("ep0_epoch_cnt", 32'(epoch_cnt), 32'd0);
        check("ep0_no_point_fetch", 32'(hi_seen), 32'd0);
        read_w(0, got);  check("ep0_w0", 32'(got), 32'h1234);
        read_w(1, got);  check("ep0_w1", 32'(got), 32'h0000);
        read_w(5, got);  check("ep0_w5", 32'(got), 32'hFEDC);
        read_w(15, got); check("ep0_w15", 32'(got), 32'h0101);

        // data_points=0 with init_w=0: weights zeroed, straight to DONE
        lat = 0;
        hi_seen = 1'b0;
        configure(4'd3, 12'd0, 8'd2, 4'd0, 1'b0);
        pulse_start();
        wait_done("dp0", 50, cyc);
        check("dp0_no_point_fetch", 32'(hi_seen), 32'd0);
        check("dp0_epoch_cnt", 32'(epoch_cnt), 32'd0);
        read_w(0, got);  check("dp0_w0", 32'(got), 32'h0000);
        read_w(5, got);  check("dp0_w5", 32'(got), 32'h0000);

        // rd_valid withheld for 5 cycles during FETCH
        mem[1] = pt(16'h0200, 16'h0100);
        lat = 5;
        configure(4'd1, 12'd1, 8'd1, 4'd0, 1'b0);
        pulse_start();
        cyc = 0;
        while (!(rd_en && addr == 12'd1) && cyc < 10) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        for (int k = 0; k < 5; k++) begin
            check($sformatf("wait%0d_rd_en", k), 32'(rd_en), 32'd1);
            check($sformatf("wait%0d_addr", k), 32'(addr), 32'd1);
            read_w(0, got);
            check($sformatf("wait%0d_w0", k), 32'(got), 32'd0);
            @(posedge CLK);
            #1;
        end
        check("wait_still_fetch", 32'(state_dbg), 32'(FETCH));
        wait_done("wait", 50, cyc);
        read_w(0, got); check("wait_w0", 32'(got), 32'h0200);
        read_w(1, got); check("wait_w1", 32'(got), 32'h0200);

        // Two points, one then two epochs: timing, wrap and epoch count
        lat = 0;
        mem[1] = pt(16'h0200, 16'h0100);
        mem[2] = pt(16'h0100, 16'h0200);
        configure(4'd1, 12'd2, 8'd1, 4'd1, 1'b0);
        pulse_start();
        wait_done("e1", 60, cyc);
        check("e1_cycles", 32'(cyc), 32'd9);
        check("e1_epoch_cnt", 32'(epoch_cnt), 32'd1);
        read_w(0, got); check("e1_w0", 32'(got), 32'h0000);
        read_w(1, got); check("e1_w1", 32'(got), 32'hFF00);
        configure(4'd1, 12'd2, 8'd2, 4'd1, 1'b0);
        pulse_start();
        wait_done("e2", 60, cyc);
        check("e2_cycles", 32'(cyc), 32'd17);
        check("e2_epoch_cnt", 32'(epoch_cnt), 32'd2);
        read_w(0, got); check("e2_w0", 32'(got), 32'h00C0);
        read_w(1, got); check("e2_w1", 32'(got), 32'hFF00);

        // Start while busy is ignored; RST in UPDATE of epoch 2 clears everything
        configure(4'd1, 12'd2, 8'd3, 4'd1, 1'b0);
        pulse_start();
        repeat (2) @(posedge CLK);
        #1;
        configure(4'd1, 12'd2, 8'd0, 4'd1, 1'b1);
        pulse_start();
        check("busy_start_state", 32'(state_dbg), 32'(ERR));
        check("busy_start_busy", 32'(busy), 32'd1);
        cyc = 0;
        while (!(state_dbg == UPDATE && epoch_cnt == 8'd1) && cyc < 100) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        check("ep2_update_reached", 32'(state_dbg == UPDATE && epoch_cnt == 8'd1), 32'd1);
        RST = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_rd_en", 32'(rd_en), 32'd0);
        check("mid_rst_addr", 32'(addr), 32'd0);
        check("mid_rst_epoch_cnt", 32'(epoch_cnt), 32'd0);
        check("mid_rst_state", 32'(state_dbg), 32'(IDLE));
        read_w(0, got); check("mid_rst_w0", 32'(got), 32'd0);
        read_w(1, got); check("mid_rst_w1", 32'(got), 32'd0);
        @(posedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK);
        #1;
        run_vec(0, "retrain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
